// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image over the uart byte stream, writes it to
// memory as 32-bit words, answers ACK/NAK and releases the CPU from reset on success.
//
// state   | meaning
// HUNT    | discard bytes until the 0xB0 sync byte
// ADDR    | collect 4 load-address bytes, little-endian
// LEN     | collect 2 payload-length bytes, little-endian
// DATA    | pack payload into words and issue memory writes
// CHECK   | receive the checksum byte
// DRAIN   | wait for the last memory write to be accepted
// RESPOND | send ACK/NAK, then release the CPU or flag an error
module uart_boot_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_complete,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_complete,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  output logic        cpu_reset,
  output logic [31:0] boot_address,
  output logic        boot_done,
  output logic        boot_error
);

  localparam logic [7:0] SYNC_BYTE = 8'hB0;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CHECK, DRAIN, RESPOND} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [1:0]    lane;
  logic [31:0]   addr_reg;
  logic [7:0]    len_lo;
  logic [15:0]   remaining;
  logic [7:0]    sum;
  logic [31:0]   word_buf;
  logic [31:0]   wr_addr;
  logic [IW-1:0] idle_cnt;

  logic [7:0]  sum_next;
  logic [15:0] len_full;
  logic [31:0] word_next;
  logic [3:0]  mask_next;
  logic        word_done;
  logic        last_byte;
  logic        timeout;

  always_comb begin
    sum_next  = sum + rx_data;
    len_full  = {rx_data, len_lo};
    word_next = word_buf;
    word_next[{lane, 3'b000} +: 8] = rx_data;
    case (lane)
      2'd0:    mask_next = 4'b0001;
      2'd1:    mask_next = 4'b0011;
      2'd2:    mask_next = 4'b0111;
      default: mask_next = 4'b1111;
    endcase
    last_byte = (remaining == 16'd1);
    word_done = (lane == 2'd3) || last_byte;
    // Idle timer only matters while a frame is being received.
    timeout   = (idle_cnt == '0) && !rx_complete &&
                (state == ADDR || state == LEN || state == DATA || state == CHECK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HUNT;
      byte_cnt     <= 2'd0;
      lane         <= 2'd0;
      addr_reg     <= 32'd0;
      len_lo       <= 8'd0;
      remaining    <= 16'd0;
      sum          <= 8'd0;
      word_buf     <= 32'd0;
      wr_addr      <= 32'd0;
      idle_cnt     <= IDLE_LOAD;
      tx_valid     <= 1'b0;
      tx_data      <= 8'd0;
      mem_request  <= 1'b0;
      mem_address  <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_wmask    <= 4'd0;
      cpu_reset    <= 1'b1;
      boot_address <= 32'd0;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
    end else begin
      boot_done <= 1'b0;
      if (mem_request && mem_ack)
        mem_request <= 1'b0;

      if (rx_complete || state == HUNT || state == DRAIN || state == RESPOND)
        idle_cnt <= IDLE_LOAD;
      else if (idle_cnt != '0)
        idle_cnt <= idle_cnt - IW'(1);

      case (state)
        HUNT: begin
          if (rx_complete && rx_data == SYNC_BYTE) begin
            cpu_reset  <= 1'b1;
            boot_error <= 1'b0;
            sum        <= 8'd0;
            byte_cnt   <= 2'd0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (timeout) begin
            boot_error <= 1'b1;
            state      <= HUNT;
          end else if (rx_complete) begin
            addr_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
            sum      <= sum_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= LEN;
          end
        end
        LEN: begin
          if (timeout) begin
            boot_error <= 1'b1;
            state      <= HUNT;
          end else if (rx_complete) begin
            sum      <= sum_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd0) begin
              len_lo <= rx_data;
            end else begin
              byte_cnt  <= 2'd0;
              remaining <= len_full;
              lane      <= 2'd0;
              word_buf  <= 32'd0;
              wr_addr   <= addr_reg & 32'hFFFF_FFFC;
              state     <= (len_full == 16'd0) ? CHECK : DATA;
            end
          end
        end
        DATA: begin
          if (timeout) begin
            boot_error <= 1'b1;
            state      <= HUNT;
          end else if (rx_complete) begin
            sum       <= sum_next;
            remaining <= remaining - 16'd1;
            if (word_done) begin
              // Single holding register: a still-pending write means overrun.
              if (mem_request && !mem_ack) begin
                boot_error <= 1'b1;
                state      <= HUNT;
              end else begin
                mem_request <= 1'b1;
                mem_address <= wr_addr;
                mem_wdata   <= word_next;
                mem_wmask   <= mask_next;
                wr_addr     <= wr_addr + 32'd4;
                word_buf    <= 32'd0;
                lane        <= 2'd0;
                if (last_byte)
                  state <= CHECK;
              end
            end else begin
              word_buf <= word_next;
              lane     <= lane + 2'd1;
            end
          end
        end
        CHECK: begin
          if (timeout) begin
            boot_error <= 1'b1;
            state      <= HUNT;
          end else if (rx_complete) begin
            sum   <= sum_next;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_request)
            state <= RESPOND;
        end
        RESPOND: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= (sum == 8'd0) ? ACK_BYTE : NAK_BYTE;
          end else if (tx_complete) begin
            tx_valid <= 1'b0;
            state    <= HUNT;
            if (tx_data == ACK_BYTE) begin
              cpu_reset    <= 1'b0;
              boot_address <= addr_reg & 32'hFFFF_FFFC;
              boot_done    <= 1'b1;
            end else begin
              boot_error <= 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frames are built with a bench-side checksum,
// memory and uart-tx responders log writes and response bytes.
module tb_uart_boot_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_complete;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete;
  logic        mem_request;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic        cpu_reset;
  logic [31:0] boot_address;
  logic        boot_done;
  logic        boot_error;

  always #5 clock = ~clock;

  uart_boot_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_complete(rx_complete), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_complete(tx_complete),
    .mem_request(mem_request), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .cpu_reset(cpu_reset), .boot_address(boot_address),
    .boot_done(boot_done), .boot_error(boot_error)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int ack_delay = 0;
  int wcnt = 0;
  int n_writes = 0;
  logic [31:0] w_addr [0:63];
  logic [31:0] w_data [0:63];
  logic [3:0]  w_mask [0:63];

  int tx_count = 0;
  logic [7:0] tx_last = 8'h00;
  int done_cnt = 0;
  logic done_rst_low = 1'b0;

  logic [7:0] pl [0:15];

  // Memory: ack after ack_delay cycles of a visible request, log the accepted write.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_request) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (n_writes < 64) begin
            w_addr[n_writes] = mem_address;
            w_data[n_writes] = mem_wdata;
            w_mask[n_writes] = mem_wmask;
          end
          n_writes++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // UART transmitter: accept each response byte one cycle after it is offered.
  initial begin
    tx_complete = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_complete) begin
        tx_complete = 1'b0;
      end else if (tx_valid) begin
        tx_last = tx_data;
        tx_count++;
        tx_complete = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (boot_done) begin
        done_cnt++;
        done_rst_low = !cpu_reset;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m);
    check({tag, "_addr"}, w_addr[idx], a);
    check({tag, "_data"}, w_data[idx], d);
    check({tag, "_mask"}, {28'd0, w_mask[idx]}, {28'd0, m});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"},
          {cpu_reset, boot_done, boot_error, tx_valid, mem_request, mem_wmask, tx_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
    check({tag, "_boot_address"}, boot_address, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock);
    rx_data = b;
    rx_complete = 1'b1;
    @(negedge clock);
    rx_complete = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [15:0] len,
                            input bit corrupt, input bit skip_sync, input int gap);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    if (!skip_sync) send_byte(8'hB0, gap);
    for (int i = 0; i < 4; i++) begin
      b = addr[8*i +: 8];
      s = s + b;
      send_byte(b, gap);
    end
    b = len[7:0];  s = s + b; send_byte(b, gap);
    b = len[15:8]; s = s + b; send_byte(b, gap);
    for (int i = 0; i < int'(len); i++) begin
      b = pl[i];
      s = s + b;
      send_byte(b, gap);
    end
    b = 8'h00 - s;
    if (corrupt) b = b + 8'h01;
    send_byte(b, gap);
  endtask

  task automatic wait_tx(input string tag, input int exp_count, input int budget);
    int left;
    left = budget;
    while (tx_count < exp_count && left > 0) begin
      @(negedge clock);
      left--;
    end
    repeat (4) @(negedge clock);
    check({tag, "_tx_count"}, tx_count, exp_count);
  endtask

  task automatic load_pl_good();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    pl[4] = 8'h55; pl[5] = 8'h66; pl[6] = 8'h77; pl[7] = 8'h88;
  endtask

  initial begin
    int base;
    int done0;
    int tx0;
    int left;

    reset_n = 1'b0;
    rx_complete = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Good frame preceded by garbage
    load_pl_good();
    base = n_writes;
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    check("garbage_ignored_err", {31'd0, boot_error}, 32'd0);
    send_frame(32'h0000_1000, 16'd8, 1'b0, 1'b0, 2);
    wait_tx("good", 1, 200);
    check("good_nwrites", n_writes - base, 2);
    check_write("good_w0", base, 32'h0000_1000, 32'h4433_2211, 4'hF);
    check_write("good_w1", base + 1, 32'h0000_1004, 32'h8877_6655, 4'hF);
    check("good_tx", {24'd0, tx_last}, 32'h06);
    check("good_boot_address", boot_address, 32'h0000_1000);
    check("good_done_cnt", done_cnt, 1);
    check("good_done_with_release", {31'd0, done_rst_low}, 32'd1);
    check("good_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("good_err", {31'd0, boot_error}, 32'd0);

    // Partial trailing word, unaligned address
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD; pl[4] = 8'hEE;
    base = n_writes;
    send_frame(32'h0000_2003, 16'd5, 1'b0, 1'b0, 2);
    wait_tx("part", 2, 200);
    check("part_nwrites", n_writes - base, 2);
    check_write("part_w0", base, 32'h0000_2000, 32'hDDCC_BBAA, 4'hF);
    check_write("part_w1", base + 1, 32'h0000_2004, 32'h0000_00EE, 4'b0001);
    check("part_tx", {24'd0, tx_last}, 32'h06);
    check("part_boot_address", boot_address, 32'h0000_2000);
    check("part_done_cnt", done_cnt, 2);

    // Bad checksum
    load_pl_good();
    base = n_writes;
    send_frame(32'h0000_1000, 16'd8, 1'b1, 1'b0, 2);
    wait_tx("bad", 3, 200);
    check("bad_nwrites", n_writes - base, 2);
    check_write("bad_w1", base + 1, 32'h0000_1004, 32'h8877_6655, 4'hF);
    check("bad_tx", {24'd0, tx_last}, 32'h15);
    check("bad_err", {31'd0, boot_error}, 32'd1);
    check("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("bad_done_cnt", done_cnt, 2);

    // Recovery: sync clears the error, frame ACKs
    send_byte(8'hB0, 2);
    check("recover_err_cleared", {31'd0, boot_error}, 32'd0);
    check("recover_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send_frame(32'h0000_1000, 16'd8, 1'b0, 1'b1, 2);
    wait_tx("recover", 4, 200);
    check("recover_tx", {24'd0, tx_last}, 32'h06);
    check("recover_done_cnt", done_cnt, 3);

    // Timeout after three address bytes
    tx0 = tx_count;
    send_byte(8'hB0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    repeat (45) @(negedge clock);
    check("timeout_not_yet", {31'd0, boot_error}, 32'd0);
    repeat (10) @(negedge clock);
    check("timeout_err", {31'd0, boot_error}, 32'd1);
    check("timeout_no_tx", tx_count, tx0);
    check("timeout_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Overrun with a slow memory
    ack_delay = 200;
    base = n_writes;
    tx0 = tx_count;
    done0 = done_cnt;
    send_frame(32'h0000_1000, 16'd8, 1'b0, 1'b0, 10);
    left = 500;
    while (n_writes == base && left > 0) begin
      @(negedge clock);
      left--;
    end
    repeat (60) @(negedge clock);
    check("ovr_nwrites", n_writes - base, 1);
    check_write("ovr_w0", base, 32'h0000_1000, 32'h4433_2211, 4'hF);
    check("ovr_err", {31'd0, boot_error}, 32'd1);
    check("ovr_no_tx", tx_count, tx0);
    check("ovr_no_done", done_cnt, done0);
    check("ovr_mem_idle", {31'd0, mem_request}, 32'd0);

    // Slow memory, slower bytes: clean load
    ack_delay = 20;
    base = n_writes;
    send_frame(32'h0000_3000, 16'd8, 1'b0, 1'b0, 38);
    wait_tx("slow", tx0 + 1, 300);
    check("slow_nwrites", n_writes - base, 2);
    check_write("slow_w1", base + 1, 32'h0000_3004, 32'h8877_6655, 4'hF);
    check("slow_tx", {24'd0, tx_last}, 32'h06);
    check("slow_err", {31'd0, boot_error}, 32'd0);
    check("slow_boot_address", boot_address, 32'h0000_3000);

    // Reset in the middle of DATA with a request pending
    ack_delay = 1000;
    send_byte(8'hB0, 2);
    send_byte(8'h00, 2); send_byte(8'h30, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    send_byte(8'h08, 2); send_byte(8'h00, 2);
    send_byte(8'h01, 2); send_byte(8'h02, 2); send_byte(8'h03, 2); send_byte(8'h04, 2);
    check("midrst_req_high", {31'd0, mem_request}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge clock);
    tx0 = tx_count;
    base = n_writes;
    send_frame(32'h0000_1000, 16'd8, 1'b0, 1'b0, 2);
    wait_tx("after_rst", tx0 + 1, 200);
    check("after_rst_nwrites", n_writes - base, 2);
    check_write("after_rst_w0", base, 32'h0000_1000, 32'h4433_2211, 4'hF);
    check("after_rst_tx", {24'd0, tx_last}, 32'h06);
    check("after_rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
